// File: rtl/subleq_pkg.sv
// subleq_pkg: shared types and constants for the SUBLEQ sequencer
package subleq_pkg;
  localparam int DATA_W = 8;
  localparam logic [7:0] OFF_A = 8'd0;
  localparam logic [7:0] OFF_B = 8'd1;
  localparam logic [7:0] OFF_C = 8'd2;
  localparam logic [7:0] INSTR_LEN = 8'd3;
  typedef enum logic [2:0] {IDLE, F_A, F_B, F_C, R_A, R_B, WB, HALT} state_t;
endpackage

// File: rtl/subleq_ctrl_subtract8.sv
// subtract8: 8-bit two's complement subtract with a no-overflow flag
module subtract8 (
  input  logic [7:0] ina,
  input  logic [7:0] inb,
  output logic [7:0] out,
  output logic       val
);
  assign out = ina - inb;
  assign val = ~((ina[7] ^ inb[7]) & (out[7] ^ ina[7]));
endmodule

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: fetch/read/write-back sequencer for the 8-bit SUBLEQ machine
module subleq_ctrl
  import subleq_pkg::*;
#(
  parameter logic [7:0] START_PC  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'hFF,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [7:0]        pc,
  output logic [CNT_W-1:0]  instr_cnt
);
  state_t state, state_n;
  logic [7:0] a_ptr, b_ptr, c_ptr;
  logic [DATA_W-1:0] a_val, diff;
  logic val, leq;
  subtract8 u_sub (.ina(mem_rdata), .inb(a_val), .out(diff), .val(val));
  // sign of the true result: an overflowed difference has its sign bit inverted
  assign leq  = (diff == '0) || (val ? diff[7] : ~diff[7]);
  assign busy = (state != IDLE) && (state != HALT);
  assign done = state == HALT;
  always_comb begin
    state_n   = state;
    mem_addr  = 8'h00;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE, HALT: state_n = start ? F_A : state;
      F_A: begin
        mem_addr = pc + OFF_A;
        state_n  = F_B;
      end
      F_B: begin
        mem_addr = pc + OFF_B;
        state_n  = F_C;
      end
      F_C: begin
        mem_addr = pc + OFF_C;
        state_n  = R_A;
      end
      R_A: begin
        mem_addr = a_ptr;
        state_n  = R_B;
      end
      R_B: begin
        mem_addr = b_ptr;
        state_n  = WB;
      end
      WB: begin
        mem_addr  = b_ptr;
        mem_we    = ~rst;
        mem_wdata = diff;
        state_n   = (leq && c_ptr == HALT_ADDR) ? HALT : F_A;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= START_PC;
      ovf       <= 1'b0;
      instr_cnt <= '0;
      a_ptr     <= '0;
      b_ptr     <= '0;
      c_ptr     <= '0;
      a_val     <= '0;
    end else begin
      state <= state_n;
      if ((state == IDLE || state == HALT) && start) begin
        pc        <= START_PC;
        ovf       <= 1'b0;
        instr_cnt <= '0;
      end
      if (state == F_B) a_ptr <= mem_rdata;
      if (state == F_C) b_ptr <= mem_rdata;
      if (state == R_A) c_ptr <= mem_rdata;
      if (state == R_B) a_val <= mem_rdata;
      if (state == WB) begin
        instr_cnt <= instr_cnt + 1'b1;
        ovf       <= ovf | ~val;
        pc        <= leq ? c_ptr : pc + INSTR_LEN;
      end
    end
  end
endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: instruction-level reference model with per-cycle bus comparison
module tb_subleq_ctrl;
  logic clk = 0, rst = 1, start = 0, start2 = 0;
  always #5 clk = ~clk;
  logic [7:0] mem_addr, mem_rdata, mem_wdata, pc;
  logic mem_we, busy, done, ovf;
  logic [15:0] instr_cnt;
  logic [7:0] mem_addr2, mem_rdata2, mem_wdata2, pc2;
  logic mem_we2, busy2, done2, ovf2;
  logic [15:0] instr_cnt2;
  subleq_ctrl u_dut (.clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .done(done), .ovf(ovf), .pc(pc), .instr_cnt(instr_cnt));
  subleq_ctrl #(.START_PC(8'hFD)) u_wrap (.clk(clk), .rst(rst), .start(start2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .busy(busy2), .done(done2), .ovf(ovf2),
    .pc(pc2), .instr_cnt(instr_cnt2));
  logic [7:0] mem [256], mem2 [256], mref [256];
  logic ld_en = 0, ld2_en = 0;
  logic [7:0] ld_addr = 0, ld_data = 0;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  always @(posedge clk) begin
    if (ld2_en) mem2[ld_addr] <= ld_data;
    else if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
    mem_rdata2 <= mem2[mem_addr2];
  end
  typedef struct {logic [7:0] addr; logic we; logic [7:0] wd; logic [7:0] pc;} cyc_t;
  cyc_t exp_q[$];
  logic [7:0] m_pc;
  int m_cnt, total = 0, bad = 0, bcnt = 0, b0 = 0;
  logic m_ovf, m_done, chk_on = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask
  // executes the program in mem from address 0 one whole instruction at a time
  task automatic model_run();
    logic [7:0] p, a, b, c;
    int r;
    p = 8'h00; mref = mem; m_cnt = 0; m_ovf = 0; m_done = 0;
    exp_q.delete();
    for (int n = 0; n < 32 && !m_done; n++) begin
      a = mref[p]; b = mref[8'(p + 8'd1)]; c = mref[8'(p + 8'd2)];
      r = int'($signed(mref[b])) - int'($signed(mref[a]));
      exp_q.push_back(cyc_t'{p, 1'b0, 8'h00, p});
      exp_q.push_back(cyc_t'{8'(p + 8'd1), 1'b0, 8'h00, p});
      exp_q.push_back(cyc_t'{8'(p + 8'd2), 1'b0, 8'h00, p});
      exp_q.push_back(cyc_t'{a, 1'b0, 8'h00, p});
      exp_q.push_back(cyc_t'{b, 1'b0, 8'h00, p});
      exp_q.push_back(cyc_t'{b, 1'b1, 8'(r), p});
      mref[b] = 8'(r);
      m_cnt++;
      if (r < -128 || r > 127) m_ovf = 1;
      if (r <= 0) begin
        p = c;
        m_done = (c == 8'hFF);
      end else p = 8'(p + 8'd3);
    end
    m_pc = p;
  endtask
  always @(negedge clk) begin
    if (busy === 1'b1) bcnt <= bcnt + 1;
    if (chk_on) begin
      if (exp_q.size() != 0) begin
        cyc_t e;
        e = exp_q.pop_front();
        chk("cyc_busy", {31'd0, busy}, 1);
        chk("cyc_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        chk("cyc_we", {31'd0, mem_we}, {31'd0, e.we & ~rst});
        if (e.we && !rst) chk("cyc_wdata", {24'd0, mem_wdata}, {24'd0, e.wd});
        chk("cyc_pc", {24'd0, pc}, {24'd0, e.pc});
      end else begin
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_we", {31'd0, mem_we}, 0);
        chk("idle_addr", {24'd0, mem_addr}, 0);
      end
    end
  end
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1;
    @(posedge clk); #1 ld_en = 0;
  endtask
  task automatic poke2(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld2_en = 1;
    @(posedge clk); #1 ld2_en = 0;
  endtask
  task automatic go();
    start = 1;
    @(posedge clk); #1 start = 0;
    model_run();
    b0 = bcnt;
  endtask
  task automatic wait_run();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1 chk("run_end", exp_q.size(), 0);
  endtask
  task automatic check_final();
    int diffs = 0;
    chk("fin_pc", {24'd0, pc}, {24'd0, m_pc});
    chk("fin_cnt", {16'd0, instr_cnt}, m_cnt);
    chk("fin_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("fin_done", {31'd0, done}, {31'd0, m_done});
    for (int i = 0; i < 256; i++) if (mem[i] !== mref[i]) diffs++;
    chk("mem_image", diffs, 0);
  endtask
  task automatic load_two();
    poke(0, 6); poke(1, 7); poke(2, 3); poke(3, 8); poke(4, 8); poke(5, 8'hFF);
    poke(6, 5); poke(7, 9); poke(8, 1);
  endtask
  logic [7:0] wrap_exp [12] = '{8'hFD, 8'hFE, 8'hFF, 8'h10, 8'h11, 8'h11,
                                8'h00, 8'h01, 8'h02, 8'h12, 8'h12, 8'h12};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", {24'd0, mem_addr}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_wdata", {24'd0, mem_wdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_pc", {24'd0, pc}, 0);
    chk("rst_cnt", {16'd0, instr_cnt}, 0);
    rst = 0; chk_on = 1;
    repeat (3) @(posedge clk);
    #1;
    load_two();
    go();
    chk("model_pc_i1", {24'd0, exp_q[6].pc}, 3);
    repeat (2) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_run();
    check_final();
    chk("two_done", {31'd0, done}, 1);
    chk("two_cnt", {16'd0, instr_cnt}, 2);
    chk("two_pc", {24'd0, pc}, 8'hFF);
    chk("two_mem7", {24'd0, mem[7]}, 4);
    chk("two_mem8", {24'd0, mem[8]}, 0);
    chk("two_busy_cycles", bcnt - b0, 12);
    poke(0, 20); poke(1, 21); poke(2, 9); poke(9, 22); poke(10, 22); poke(11, 8'hFF);
    poke(20, 125); poke(21, 8'h92); poke(22, 3);
    go();
    chk("rs_done", {31'd0, done}, 0);
    chk("rs_cnt", {16'd0, instr_cnt}, 0);
    chk("rs_pc", {24'd0, pc}, 0);
    chk("model_ovf_wd", {24'd0, exp_q[5].wd}, 8'h15);
    chk("model_ovf_pc", {24'd0, exp_q[6].pc}, 9);
    wait_run();
    check_final();
    chk("ovf_set", {31'd0, ovf}, 1);
    chk("ovf_mem21", {24'd0, mem[21]}, 8'h15);
    load_two();
    go();
    chk("rs_ovf_clear", {31'd0, ovf}, 0);
    wait_run();
    check_final();
    poke(0, 30); poke(1, 31); poke(2, 3); poke(3, 30); poke(4, 32); poke(5, 8'hFF);
    poke(30, 1); poke(31, 7); poke(32, 9);
    go();
    repeat (10) @(posedge clk);
    #1 chk("mid_cnt_before", {16'd0, instr_cnt}, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("mid_we", {31'd0, mem_we}, 0);
    chk("mid_mem32", {24'd0, mem[32]}, 9);
    chk("mid_cnt", {16'd0, instr_cnt}, 0);
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_pc", {24'd0, pc}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("mid_done", {31'd0, done}, 0);
    poke2(8'hFD, 8'h10); poke2(8'hFE, 8'h11); poke2(8'hFF, 8'h00);
    poke2(8'h10, 1); poke2(8'h11, 5); poke2(8'h12, 3);
    poke2(8'h00, 8'h12); poke2(8'h01, 8'h12); poke2(8'h02, 8'hFF);
    start2 = 1;
    @(posedge clk); #1 start2 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("wrap_addr", {24'd0, mem_addr2}, {24'd0, wrap_exp[i]});
      if (i == 6) chk("wrap_pc", {24'd0, pc2}, 0);
    end
    @(posedge clk); #1;
    chk("wrap_done", {31'd0, done2}, 1);
    chk("wrap_busy", {31'd0, busy2}, 0);
    chk("wrap_cnt", {16'd0, instr_cnt2}, 2);
    chk("wrap_ovf", {31'd0, ovf2}, 0);
    chk("wrap_mem", {24'd0, mem2[8'h11]}, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
